uart_tx_arbiter: RTL

//   Shares one uartTx transmitter between NUM_CH requesters. Picks a requester round-robin.

---
 rtl/uart_tx_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one uartTx between NUM_CH requesters.
// Optional stall timeout on a held lock: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int CH_W          = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [8*NUM_CH-1:0]   req_data,
  input  logic [NUM_CH-1:0]     req_last,
  output logic [NUM_CH-1:0]     req_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  grant_active,
  output logic [CH_W-1:0]       grant_id,
  output logic                  timeout_err
);

  localparam int SUMW = CH_W + 1;
  localparam logic [SUMW-1:0] NUM_CH_W = SUMW'(NUM_CH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter values");
  end

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              lock_q, lock_d;
  logic [CH_W-1:0]   grant_id_q, grant_id_d;
  logic [7:0]        hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;
  logic [NUM_CH-1:0] req_ready_q, req_ready_d;
  logic              wait_cnt_q, wait_cnt_d;
  logic              reissued_q, reissued_d;
  logic              timeout_err_q, timeout_err_d;
`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  logic              sel_found;
  logic [CH_W-1:0]   sel_idx;
  logic [SUMW-1:0]   sum;

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  // Round-robin search from rr_ptr; a held lock overrides it with the owner only.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      sum = {1'b0, rr_ptr_q} + SUMW'(off);
      if (sum >= NUM_CH_W) sum = sum - NUM_CH_W;
      if (!sel_found && req_valid[sum[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = sum[CH_W-1:0];
      end
    end
    if (lock_q) begin
      sel_found = req_valid[grant_id_q];
      sel_idx   = grant_id_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    lock_d        = lock_q;
    grant_id_d    = grant_id_q;
    hold_data_d   = hold_data_q;
    hold_last_d   = hold_last_q;
    req_ready_d   = '0;
    wait_cnt_d    = wait_cnt_q;
    reissued_d    = reissued_q;
    timeout_err_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_ready && sel_found) begin
          req_ready_d[sel_idx] = 1'b1;
          hold_data_d          = req_data[8*sel_idx +: 8];
          hold_last_d          = req_last[sel_idx];
          grant_id_d           = sel_idx;
          lock_d               = 1'b1;
          reissued_d           = 1'b0;
          state_d              = S_START;
`ifdef UART_ARB_TIMEOUT_EN
          tmo_cnt_d            = '0;
`endif
        end
      end
      S_START: begin
        wait_cnt_d = 1'b0;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A start the transmitter missed is re-issued once after two ready cycles.
        if (!tx_ready) begin
          state_d = S_WAIT_DONE;
        end else if (!wait_cnt_q) begin
          wait_cnt_d = 1'b1;
        end else if (!reissued_q) begin
          reissued_d = 1'b1;
          state_d    = S_START;
        end
      end
      default: begin
        if (tx_ready) begin
          state_d = S_IDLE;
          if (hold_last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = ch_inc(grant_id_q);
          end
        end
      end
    endcase
`ifdef UART_ARB_TIMEOUT_EN
    if (lock_q && state_q == S_IDLE && !req_valid[grant_id_q]) begin
      if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
        lock_d        = 1'b0;
        timeout_err_d = 1'b1;
        rr_ptr_d      = ch_inc(grant_id_q);
        tmo_cnt_d     = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      lock_q        <= 1'b0;
      grant_id_q    <= '0;
      hold_data_q   <= '0;
      hold_last_q   <= 1'b0;
      req_ready_q   <= '0;
      wait_cnt_q    <= 1'b0;
      reissued_q    <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      grant_id_q    <= grant_id_d;
      hold_data_q   <= hold_data_d;
      hold_last_q   <= hold_last_d;
      req_ready_q   <= req_ready_d;
      wait_cnt_q    <= wait_cnt_d;
      reissued_q    <= reissued_d;
      timeout_err_q <= timeout_err_d;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  // tx_start is decoded from state so an asynchronous reset removes it at once.
  assign tx_start     = (state_q == S_START);
  assign tx_data      = hold_data_q;
  assign req_ready    = req_ready_q;
  assign grant_active = lock_q;
  assign grant_id     = grant_id_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err  = timeout_err_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule
